// File: rtl/wb_regfile.sv
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : MEM/WB pipeline register and 32x32 GPR file with two
//             combinational read ports. Optional writeback-to-read bypass
//             is compiled in with the macro WB_BYPASS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int REG_ADDR_BUS_WIDTH = 5,
    parameter int REG_DATA_BUS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] wd_i,
    input  logic                          wreg_i,
    input  logic [REG_DATA_BUS_WIDTH-1:0] wdata_i,
    input  logic                          re1_i,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] raddr1_i,
    output logic [REG_DATA_BUS_WIDTH-1:0] rdata1_o,
    input  logic                          re2_i,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] raddr2_i,
    output logic [REG_DATA_BUS_WIDTH-1:0] rdata2_o,
    output logic [REG_ADDR_BUS_WIDTH-1:0] wb_wd_o,
    output logic                          wb_wreg_o,
    output logic [REG_DATA_BUS_WIDTH-1:0] wb_wdata_o
);

    localparam int                          NUM_REGS     = 2 ** REG_ADDR_BUS_WIDTH;
    localparam int                          NUM_RD_PORTS = 2;
    localparam logic [REG_ADDR_BUS_WIDTH-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_DATA_BUS_WIDTH-1:0] ZERO_WORD    = '0;

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    logic [REG_ADDR_BUS_WIDTH-1:0] wb_wd_q,    wb_wd_d;
    logic                          wb_wreg_q,  wb_wreg_d;
    logic [REG_DATA_BUS_WIDTH-1:0] wb_wdata_q, wb_wdata_d;

    // Flush outranks stall so a squashed instruction can never be held.
    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        if (flush_i) begin
            wb_wd_d    = NOP_REG_ADDR;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = ZERO_WORD;
        end else if (!stall_i) begin
            wb_wd_d    = wd_i;
            wb_wreg_d  = wreg_i;
            wb_wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd_q    <= NOP_REG_ADDR;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= ZERO_WORD;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    assign wb_wd_o    = wb_wd_q;
    assign wb_wreg_o  = wb_wreg_q;
    assign wb_wdata_o = wb_wdata_q;

    // ------------------------------------------------------------------
    // Register array; r0 is never written so it stays at its reset zero.
    // ------------------------------------------------------------------
    logic [REG_DATA_BUS_WIDTH-1:0] regs_q [NUM_REGS];
    logic                          w_commit;

    assign w_commit = wb_wreg_q && (wb_wd_q != NOP_REG_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else if (w_commit) begin
            regs_q[wb_wd_q] <= wb_wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [NUM_RD_PORTS-1:0]                         w_re;
    logic [NUM_RD_PORTS-1:0][REG_ADDR_BUS_WIDTH-1:0] w_raddr;

    assign w_re    = {re2_i, re1_i};
    assign w_raddr = {raddr2_i, raddr1_i};

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
        logic [REG_DATA_BUS_WIDTH-1:0] rdata;

        always_comb begin
            rdata = ZERO_WORD;
            if (w_re[p] && (w_raddr[p] != NOP_REG_ADDR)) begin
`ifdef WB_BYPASS_EN
                if (w_commit && (wb_wd_q == w_raddr[p])) begin
                    rdata = wb_wdata_q;
                end else begin
                    rdata = regs_q[w_raddr[p]];
                end
`else
                rdata = regs_q[w_raddr[p]];
`endif
            end
        end
    end

    assign rdata1_o = g_rd_port[0].rdata;
    assign rdata2_o = g_rd_port[1].rdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Directed scoreboard bench for wb_regfile (bypass-aware).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        re1_i = 1'b1;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic        re2_i = 1'b1;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .wb_wdata_o (wb_wdata_o)
    );

    always #5 clk = clk_en ? ~clk : clk;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Output selectors for scoreboard entries
    localparam int S_RD1 = 0, S_RD2 = 1, S_WD = 2, S_WREG = 3, S_WDATA = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      sample;
    int        n_vec  = 0;
    int        n_fail = 0;

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_point();
        -> sample;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: drains the scoreboard against the live outputs
    initial begin
        sb_entry_t   e;
        logic [31:0] act;
        forever begin
            @(sample);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    S_RD1:   act = rdata1_o;
                    S_RD2:   act = rdata2_o;
                    S_WD:    act = {27'd0, wb_wd_o};
                    S_WREG:  act = {31'd0, wb_wreg_o};
                    default: act = wb_wdata_o;
                endcase
                n_vec++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_wb(input string tag, input logic [4:0] wd, input logic wreg,
                             input logic [31:0] wdata);
        expect_val({tag, "_wd"},    S_WD,    {27'd0, wd});
        expect_val({tag, "_wreg"},  S_WREG,  {31'd0, wreg});
        expect_val({tag, "_wdata"}, S_WDATA, wdata);
    endtask

    initial begin
        // Reset with the clock stopped
        #5 rst = 1'b1;
        #5;
        expect_wb("rst", 5'd0, 1'b0, 32'h0);
        check_point();
        for (int a = 0; a < 32; a++) begin
            raddr1_i = 5'(a);
            raddr2_i = 5'(31 - a);
            #1;
            expect_val("rst_rd1", S_RD1, 32'h0);
            expect_val("rst_rd2", S_RD2, 32'h0);
            check_point();
        end

        clk_en = 1'b1;
        step();
        rst = 1'b0;

        // Basic commit of r5
        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'hDEADBEEF; raddr1_i = 5'd5;
        step();
        expect_wb("commit", 5'd5, 1'b1, 32'hDEADBEEF);
        expect_val("commit_byp_rd1", S_RD1, BYP ? 32'hDEADBEEF : 32'h0);
        check_point();
        wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        step();
        expect_val("commit_arr_rd1", S_RD1, 32'hDEADBEEF);
        expect_val("commit_idle_wreg", S_WREG, 32'h0);
        check_point();

        // r0 protection
        wd_i = 5'd0; wreg_i = 1'b1; wdata_i = 32'h12345678; raddr2_i = 5'd0; raddr1_i = 5'd0;
        step();
        expect_wb("r0", 5'd0, 1'b1, 32'h12345678);
        expect_val("r0_byp_rd2", S_RD2, 32'h0);
        expect_val("r0_byp_rd1", S_RD1, 32'h0);
        check_point();
        wreg_i = 1'b0; wdata_i = 32'h0;
        step();
        expect_val("r0_arr_rd2", S_RD2, 32'h0);
        check_point();

        // Stall then flush
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hA;
        step();
        expect_wb("load_r7", 5'd7, 1'b1, 32'hA);
        check_point();
        stall_i = 1'b1; wd_i = 5'd8; wdata_i = 32'hB; raddr1_i = 5'd8; raddr2_i = 5'd7;
        for (int c = 0; c < 3; c++) begin
            step();
            expect_wb("stall", 5'd7, 1'b1, 32'hA);
            expect_val("stall_r8", S_RD1, 32'h0);
            expect_val("stall_r7", S_RD2, 32'hA);
            check_point();
        end
        flush_i = 1'b1;
        step();
        expect_wb("flush", 5'd0, 1'b0, 32'h0);
        expect_val("flush_r8", S_RD1, 32'h0);
        check_point();
        flush_i = 1'b0; stall_i = 1'b0; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
        step();
        step();
        expect_val("post_flush_r8", S_RD1, 32'h0);
        expect_val("post_flush_r7", S_RD2, 32'hA);
        check_point();

        // Dual read and enable gating
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h33;
        step();
        wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
        step();
        raddr1_i = 5'd3; raddr2_i = 5'd3;
        #1;
        expect_val("dual_rd1", S_RD1, 32'h33);
        expect_val("dual_rd2", S_RD2, 32'h33);
        check_point();
        re2_i = 1'b0;
        #1;
        expect_val("re2_off_rd2", S_RD2, 32'h0);
        expect_val("re2_off_rd1", S_RD1, 32'h33);
        check_point();
        re2_i = 1'b1; re1_i = 1'b0;
        #1;
        expect_val("re1_off_rd1", S_RD1, 32'h0);
        expect_val("re1_off_rd2", S_RD2, 32'h33);
        check_point();
        re1_i = 1'b1;

        // Async reset in the middle of an r9 commit
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h99; raddr1_i = 5'd9;
        step();
        expect_wb("pre_rst_r9", 5'd9, 1'b1, 32'h99);
        check_point();
        rst = 1'b1;
        #1;
        expect_wb("mid_rst", 5'd0, 1'b0, 32'h0);
        expect_val("mid_rst_r9", S_RD1, 32'h0);
        expect_val("mid_rst_r3", S_RD2, 32'h0);
        check_point();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h55;
        step();
        expect_wb("post_rst_r9", 5'd9, 1'b1, 32'h55);
        check_point();
        wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
        step();
        expect_val("post_rst_rd9", S_RD1, 32'h55);
        check_point();

        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Writeback end of the MEM→WB interface: captures the destination address, write-enable and result driven by the memory-access stage into the MEM/WB pipeline register, then commits them into a 32×32-bit general-purpose register file one cycle later. It also provides the two combinational read ports used by the decode stage, with optional writeback-to-read bypass. It is the terminal stage of the five-stage pipeline.

## Interface
Parameters (widths taken from `defines.v`):
- `reg_addr_bus_width`: 5 bits (4:0), register address.
- `reg_data_bus_width`: 32 bits (31:0), register data.
- `NOPRegAddr`: 5'b00000, bubble destination.
- `zero_word`: 32'h0.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high (`enable_signal`).
- `stall_i`  in  1  hold the MEM/WB register.
- `flush_i`  in  1  load a bubble into the MEM/WB register.
- `wd_i`  in  5  destination register from the MEM stage.
- `wreg_i`  in  1  write request from the MEM stage.
- `wdata_i`  in  32  result from the MEM stage.
- `re1_i`  in  1  read-port-1 enable.
- `raddr1_i`  in  5  read-port-1 address.
- `rdata1_o`  out  32  read-port-1 data (combinational).
- `re2_i`  in  1  read-port-2 enable.
- `raddr2_i`  in  5  read-port-2 address.
- `rdata2_o`  out  32  read-port-2 data (combinational).
- `wb_wd_o`  out  5  registered WB destination (for the forwarding unit).
- `wb_wreg_o`  out  1  registered WB write enable.
- `wb_wdata_o`  out  32  registered WB data.

## Operation
- MEM/WB register, evaluated on each rising `clk`, in this priority:
  - `flush_i=1`: load a bubble (`wb_wd_o=NOPRegAddr`, `wb_wreg_o=0`, `wb_wdata_o=zero_word`). Flush overrides stall.
  - else `stall_i=1`: hold the current contents.
  - else: load `wd_i`, `wreg_i`, `wdata_i`.
- Register file write, on each rising `clk`: if `wb_wreg_o=1` and `wb_wd_o≠0`, write `regs[wb_wd_o] <= wb_wdata_o`.
  - Writes to r0 are discarded; r0 always reads 0.
  - During a stall the held entry rewrites the same value each cycle. This is idempotent and is legal.
- Read port n (combinational, both ports identical and independent):
  - `re_n=0`: output 0.
  - `raddr_n=0`: output 0.
  - bypass hit (see Configuration): output `wb_wdata_o`.
  - otherwise: output `regs[raddr_n]`.
- Both read ports may address the same register simultaneously; both return the same value.
- Reset (async assert; takes effect with no clock required):
  - `wb_wd_o=0`, `wb_wreg_o=0`, `wb_wdata_o=0`.
  - All 32 registers cleared to 0.
  - Read outputs therefore return 0.
- Deassertion of `rst` is synchronous to `clk` (synchronised externally). The first capture happens on the first rising edge after deassertion.
- Reset mid-stall or mid-flush: reset wins; stall and flush are ignored while `rst=1`.

## Timing
- Result presented on `wd_i`/`wreg_i`/`wdata_i` in cycle N:
  - appears on `wb_*_o` in cycle N+1;
  - is written to the array at the end of N+1;
  - is readable from the array from cycle N+2.
- With bypass compiled in, the result is also readable in cycle N+1 through the bypass.
- A stall asserted in cycle N keeps `wb_*_o` unchanged in N+1.
- A flush asserted in cycle N makes N+1 a bubble; no array write occurs at the end of N+1.
- Read-port latency is zero (combinational from `raddr`, `re` and the current state).

## Configuration
- Macro `WB_BYPASS_EN`.
- Defined: a read port returns `wb_wdata_o` when `re_n=1`, `raddr_n≠0`, `wb_wreg_o=1` and `wb_wd_o=raddr_n`. This gives same-cycle write-then-read visibility.
- Undefined: reads always come from the array. A read in the commit cycle returns the old value, and the decode stage must cover the hazard by stalling or external forwarding.

## Test plan
- Reset: assert `rst` with `clk` stopped → all `wb_*_o=0`; `rdata1_o`/`rdata2_o` read 0 for every address.
- Basic commit: drive `wd_i=5`, `wreg_i=1`, `wdata_i=32'hDEADBEEF` in cycle N → `wb_wd_o=5` in N+1; `raddr1_i=5` reads DEADBEEF from N+2. In N+1 the read returns DEADBEEF with `WB_BYPASS_EN`, and 0 without it.
- r0 protection: drive `wd_i=0`, `wreg_i=1`, `wdata_i=32'h12345678` → `raddr2_i=0` reads 0 in all following cycles, including the bypass cycle.
- Stall then flush: load r7=0xA, then assert `stall_i` for 3 cycles while `wd_i` changes to r8/0xB → `wb_*_o` holds r7/0xA and r8 stays 0. Then assert `flush_i` together with `stall_i` → bubble; r8 never written.
- Dual read/`re` gating: r3=0x33 committed; `raddr1_i=raddr2_i=3` → both ports read 0x33. Drop `re2_i` → `rdata2_o=0` while `rdata1_o=0x33`.
- Async reset mid-operation: assert `rst` between clock edges during a commit of r9=0x99 → r9 reads 0 immediately and `wb_wreg_o=0`. After deassertion, the next commit of r9=0x55 reads 0x55.
